// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, fetches 32-bit instructions from a 64-bit
// memory with one request in flight, and hands them to decode over valid/ready.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [63:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_fault
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] inst_reg, inst_next;
  logic [31:0] inst_pc_reg, inst_pc_next;
  logic        fault_reg, fault_next;
  logic        discard_reg, discard_next;
  logic        launch;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg   <= S_IDLE;
      pc_reg      <= RESET_PC;
      inst_reg    <= 32'h0;
      inst_pc_reg <= RESET_PC;
      fault_reg   <= 1'b0;
      discard_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      inst_reg    <= inst_next;
      inst_pc_reg <= inst_pc_next;
      fault_reg   <= fault_next;
      discard_reg <= discard_next;
    end
  end

  // 'launch' means "start fetching pc_next": a request if aligned, otherwise a
  // faulting instruction presented directly without touching memory.
  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    inst_next    = inst_reg;
    inst_pc_next = inst_pc_reg;
    fault_next   = fault_reg;
    discard_next = discard_reg;
    launch       = 1'b0;

    if (redirect_valid) begin
      pc_next = redirect_pc;
      case (state_reg)
        S_IDLE, S_HOLD: launch = 1'b1;
        S_REQ: begin
          if (imem_gnt) begin
            discard_next = 1'b1;
            state_next   = S_WAIT;
          end else begin
            launch = 1'b1;
          end
        end
        S_WAIT: begin
          // A response arriving now is the stale one; otherwise drop the next.
          if (imem_rvalid) begin
            discard_next = 1'b0;
            launch       = 1'b1;
          end else begin
            discard_next = 1'b1;
          end
        end
        default: launch = 1'b1;
      endcase
    end else begin
      case (state_reg)
        S_IDLE: launch = 1'b1;
        S_REQ: begin
          if (imem_gnt) state_next = S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (discard_reg) begin
              discard_next = 1'b0;
              launch       = 1'b1;
            end else begin
              inst_next    = pc_reg[2] ? imem_rdata[63:32] : imem_rdata[31:0];
              inst_pc_next = pc_reg;
              fault_next   = 1'b0;
              state_next   = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (inst_ready) begin
            pc_next = pc_reg + 32'd4;
            launch  = 1'b1;
          end
        end
        default: launch = 1'b1;
      endcase
    end

    if (launch) begin
      if (pc_next[1:0] != 2'b00) begin
        state_next   = S_HOLD;
        inst_next    = 32'h0;
        inst_pc_next = pc_next;
        fault_next   = 1'b1;
      end else begin
        state_next = S_REQ;
      end
    end
  end

  assign imem_req   = (state_reg == S_REQ);
  assign imem_addr  = {pc_reg[31:3], 3'b000};
  assign inst_valid = (state_reg == S_HOLD) && !redirect_valid;
  assign inst       = inst_reg;
  assign inst_pc    = inst_pc_reg;
  assign inst_fault = fault_reg;

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: cycle-accurate vector table, directed corner sequences,
// then a randomized run checked against an instruction-stream reference model.
module tb_ifu_fetch;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [63:0] imem_rdata = 64'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;

  always #5 clk = ~clk;

  ifu_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rstn(rstn),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc), .inst_fault(inst_fault)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        gnt;
    logic        rv;
    logic [63:0] rdata;
    logic        rd;
    logic [31:0] rdpc;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_val;
    logic [31:0] e_inst;
    logic [31:0] e_ipc;
    logic        e_flt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic gnt, input logic rv, input logic [63:0] rdata,
                     input logic rd, input logic [31:0] rdpc, input logic rdy,
                     input logic e_req, input logic [31:0] e_addr, input logic e_val,
                     input logic [31:0] e_inst, input logic [31:0] e_ipc, input logic e_flt);
    vec_t v;
    v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.rd = rd; v.rdpc = rdpc; v.rdy = rdy;
    v.e_req = e_req; v.e_addr = e_addr; v.e_val = e_val;
    v.e_inst = e_inst; v.e_ipc = e_ipc; v.e_flt = e_flt;
    vecs.push_back(v);
  endtask

  // Inputs are applied just after the falling edge; outputs are read 1 ns later.
  task automatic drive(input logic gnt, input logic rv, input logic [63:0] rdata,
                       input logic rd, input logic [31:0] rdpc, input logic rdy);
    @(negedge clk);
    imem_gnt = gnt; imem_rvalid = rv; imem_rdata = rdata;
    redirect_valid = rd; redirect_pc = rdpc; inst_ready = rdy;
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    imem_gnt = 1'b0; imem_rvalid = 1'b0; redirect_valid = 1'b0; inst_ready = 1'b0;
    rstn = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rstn = 1'b1;
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'hC0DE_F00D;
  endfunction

  function automatic logic [63:0] mem64(input logic [31:0] a);
    logic [31:0] a8;
    a8 = {a[31:3], 3'b000};
    return {word_at(a8 + 32'd4), word_at(a8)};
  endfunction

  function automatic logic [31:0] pick_pc();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 32'hFFFF_FFF8 + 32'($urandom_range(0, 1) * 4);
    if (r == 1) return 32'h8000_0002 + 32'($urandom_range(0, 63) * 4);
    return 32'h8000_0000 + 32'($urandom_range(0, 255) * 4);
  endfunction

  localparam logic [63:0] D1 = 64'h00500093_00100093;
  localparam logic [63:0] JK = 64'hBAD0_BAD0_BAD0_BAD0;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        ok;
    logic        pend;
    int          cnt;
    logic [31:0] paddr;
    logic [31:0] exp_pc;
    logic        exp_flt;
    logic [31:0] exp_inst;
    int          consumed;
    logic        prev_val, prev_rdy, prev_rd, prev_flt;
    logic [31:0] prev_inst, prev_ipc;

    // ---------------- reset values ----------------
    #3 rstn = 1'b0;
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, RESET_PC);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, RESET_PC);
    chk("rst_fault", 32'(inst_fault), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #2 rstn = 1'b1;

    // ---------------- cycle-by-cycle table ----------------
    //   gnt rv rdata                     rd rdpc          rdy | req addr          val inst          ipc           flt
    add(1, 0, 64'h0,                      0, 32'h0,         1,  0, 32'h8000_0000, 0, 32'h0,         32'h0,         0);
    add(1, 0, 64'h0,                      0, 32'h0,         1,  1, 32'h8000_0000, 0, 32'h0,         32'h0,         0);
    add(0, 1, D1,                         0, 32'h0,         1,  0, 32'h8000_0000, 0, 32'h0,         32'h0,         0);
    add(0, 0, 64'h0,                      0, 32'h0,         1,  0, 32'h8000_0000, 1, 32'h0010_0093, 32'h8000_0000, 0);
    add(1, 0, 64'h0,                      0, 32'h0,         1,  1, 32'h8000_0000, 0, 32'h0,         32'h0,         0);
    add(0, 1, D1,                         0, 32'h0,         1,  0, 32'h8000_0000, 0, 32'h0,         32'h0,         0);
    add(0, 0, 64'h0,                      0, 32'h0,         1,  0, 32'h8000_0000, 1, 32'h0050_0093, 32'h8000_0004, 0);
    add(0, 0, 64'h0,                      0, 32'h0,         1,  1, 32'h8000_0008, 0, 32'h0,         32'h0,         0);
    add(0, 1, JK,                         0, 32'h0,         1,  1, 32'h8000_0008, 0, 32'h0,         32'h0,         0);
    add(0, 0, 64'h0,                      0, 32'h0,         1,  1, 32'h8000_0008, 0, 32'h0,         32'h0,         0);
    add(0, 0, 64'h0,                      0, 32'h0,         1,  1, 32'h8000_0008, 0, 32'h0,         32'h0,         0);
    add(1, 0, 64'h0,                      0, 32'h0,         1,  1, 32'h8000_0008, 0, 32'h0,         32'h0,         0);
    add(0, 1, 64'h11111111_22222222,      0, 32'h0,         0,  0, 32'h8000_0008, 0, 32'h0,         32'h0,         0);
    add(0, 1, JK,                         0, 32'h0,         0,  0, 32'h8000_0008, 1, 32'h2222_2222, 32'h8000_0008, 0);
    add(0, 0, 64'h0,                      0, 32'h0,         0,  0, 32'h8000_0008, 1, 32'h2222_2222, 32'h8000_0008, 0);
    add(0, 0, 64'h0,                      0, 32'h0,         0,  0, 32'h8000_0008, 1, 32'h2222_2222, 32'h8000_0008, 0);
    add(0, 0, 64'h0,                      0, 32'h0,         1,  0, 32'h8000_0008, 1, 32'h2222_2222, 32'h8000_0008, 0);
    add(1, 0, 64'h0,                      0, 32'h0,         1,  1, 32'h8000_0008, 0, 32'h0,         32'h0,         0);
    add(0, 0, 64'h0,                      1, 32'h8000_0100, 1,  0, 32'h8000_0008, 0, 32'h0,         32'h0,         0);
    add(0, 0, 64'h0,                      0, 32'h0,         1,  0, 32'h8000_0100, 0, 32'h0,         32'h0,         0);
    add(0, 1, 64'hDEADBEEF_DEADBEEF,      0, 32'h0,         1,  0, 32'h8000_0100, 0, 32'h0,         32'h0,         0);
    add(1, 0, 64'h0,                      0, 32'h0,         1,  1, 32'h8000_0100, 0, 32'h0,         32'h0,         0);
    add(0, 1, 64'h33333333_44444444,      0, 32'h0,         1,  0, 32'h8000_0100, 0, 32'h0,         32'h0,         0);
    add(0, 0, 64'h0,                      1, 32'h8000_0200, 1,  0, 32'h8000_0100, 0, 32'h0,         32'h0,         0);
    add(1, 0, 64'h0,                      0, 32'h0,         1,  1, 32'h8000_0200, 0, 32'h0,         32'h0,         0);
    add(0, 1, 64'h55555555_66666666,      0, 32'h0,         1,  0, 32'h8000_0200, 0, 32'h0,         32'h0,         0);
    add(0, 0, 64'h0,                      0, 32'h0,         1,  0, 32'h8000_0200, 1, 32'h6666_6666, 32'h8000_0200, 0);
    add(0, 0, 64'h0,                      1, 32'h8000_0102, 1,  1, 32'h8000_0200, 0, 32'h0,         32'h0,         0);
    add(0, 0, 64'h0,                      0, 32'h0,         0,  0, 32'h8000_0100, 1, 32'h0,         32'h8000_0102, 1);
    add(0, 0, 64'h0,                      0, 32'h0,         1,  0, 32'h8000_0100, 1, 32'h0,         32'h8000_0102, 1);
    add(0, 0, 64'h0,                      0, 32'h0,         0,  0, 32'h8000_0100, 1, 32'h0,         32'h8000_0106, 1);
    add(0, 0, 64'h0,                      1, 32'hFFFF_FFFC, 0,  0, 32'h8000_0100, 0, 32'h0,         32'h0,         0);
    add(1, 0, 64'h0,                      0, 32'h0,         1,  1, 32'hFFFF_FFF8, 0, 32'h0,         32'h0,         0);
    add(0, 1, 64'h77777777_88888888,      0, 32'h0,         1,  0, 32'hFFFF_FFF8, 0, 32'h0,         32'h0,         0);
    add(0, 0, 64'h0,                      0, 32'h0,         1,  0, 32'hFFFF_FFF8, 1, 32'h7777_7777, 32'hFFFF_FFFC, 0);
    add(1, 0, 64'h0,                      0, 32'h0,         1,  1, 32'h0000_0000, 0, 32'h0,         32'h0,         0);
    add(0, 1, 64'h99999999_AAAAAAAA,      0, 32'h0,         1,  0, 32'h0000_0000, 0, 32'h0,         32'h0,         0);
    add(0, 0, 64'h0,                      0, 32'h0,         1,  0, 32'h0000_0000, 1, 32'hAAAA_AAAA, 32'h0000_0000, 0);
    add(0, 0, 64'h0,                      0, 32'h0,         1,  1, 32'h0000_0000, 0, 32'h0,         32'h0,         0);

    foreach (vecs[i]) begin
      drive(vecs[i].gnt, vecs[i].rv, vecs[i].rdata, vecs[i].rd, vecs[i].rdpc, vecs[i].rdy);
      ok = (imem_req === vecs[i].e_req) && (imem_addr === vecs[i].e_addr) &&
           (inst_valid === vecs[i].e_val) &&
           (!vecs[i].e_val || ((inst === vecs[i].e_inst) && (inst_pc === vecs[i].e_ipc) &&
                               (inst_fault === vecs[i].e_flt)));
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL vec%0d actual req=%b addr=%h val=%b inst=%h pc=%h flt=%b expected req=%b addr=%h val=%b inst=%h pc=%h flt=%b",
                 i, imem_req, imem_addr, inst_valid, inst, inst_pc, inst_fault,
                 vecs[i].e_req, vecs[i].e_addr, vecs[i].e_val, vecs[i].e_inst, vecs[i].e_ipc, vecs[i].e_flt);
      end else begin
        $display("vec%0d req=%b addr=%h val=%b inst=%h pc=%h flt=%b",
                 i, imem_req, imem_addr, inst_valid, inst, inst_pc, inst_fault);
      end
    end

    // ---------------- redirect in REQ with gnt, then again while discarding ----------------
    drive(1, 0, 64'h0, 1, 32'h8000_0400, 0);
    chk("rq_gnt_redir_req", 32'(imem_req), 32'd1);
    chk("rq_gnt_redir_val", 32'(inst_valid), 32'd0);
    drive(0, 0, 64'h0, 1, 32'h8000_0800, 0);
    chk("double_redir_req", 32'(imem_req), 32'd0);
    drive(0, 1, JK, 0, 32'h0, 1);
    chk("stale_drop_val", 32'(inst_valid), 32'd0);
    chk("stale_drop_req", 32'(imem_req), 32'd0);
    drive(1, 0, 64'h0, 0, 32'h0, 1);
    chk("refetch_req", 32'(imem_req), 32'd1);
    chk("refetch_addr", imem_addr, 32'h8000_0800);
    drive(0, 1, 64'hCCCCCCCC_BBBBBBBB, 0, 32'h0, 0);
    chk("refetch_wait_req", 32'(imem_req), 32'd0);
    drive(0, 0, 64'h0, 0, 32'h0, 0);
    chk("refetch_val", 32'(inst_valid), 32'd1);
    chk("refetch_inst", inst, 32'hBBBB_BBBB);
    chk("refetch_pc", inst_pc, 32'h8000_0800);
    drive(0, 0, 64'h0, 0, 32'h0, 1);
    drive(1, 0, 64'h0, 0, 32'h0, 0);
    chk("next_req_addr", imem_addr, 32'h8000_0800);

    // ---------------- reset while a response is outstanding ----------------
    #1 rstn = 1'b0;
    #1;
    chk("midrst_req", 32'(imem_req), 32'd0);
    chk("midrst_val", 32'(inst_valid), 32'd0);
    chk("midrst_addr", imem_addr, RESET_PC);
    chk("midrst_inst_pc", inst_pc, RESET_PC);
    @(posedge clk);
    #2 rstn = 1'b1;
    drive(0, 1, 64'hEEEEEEEE_EEEEEEEE, 0, 32'h0, 1);
    chk("postrst_idle_req", 32'(imem_req), 32'd0);
    drive(1, 0, 64'h0, 0, 32'h0, 1);
    chk("postrst_req", 32'(imem_req), 32'd1);
    chk("postrst_addr", imem_addr, RESET_PC);
    drive(0, 1, 64'h0BAD0BAD_12345678, 0, 32'h0, 1);
    drive(0, 0, 64'h0, 0, 32'h0, 1);
    chk("postrst_val", 32'(inst_valid), 32'd1);
    chk("postrst_inst", inst, 32'h1234_5678);
    chk("postrst_pc", inst_pc, RESET_PC);

    // ---------------- randomized run against instruction-stream model ----------------
    do_reset();
    pend = 1'b0; cnt = 0; paddr = 32'h0;
    exp_pc = RESET_PC; consumed = 0;
    prev_val = 1'b0; prev_rdy = 1'b0; prev_rd = 1'b0; prev_flt = 1'b0;
    prev_inst = 32'h0; prev_ipc = 32'h0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      imem_rvalid    = pend && (cnt == 0);
      imem_rdata     = imem_rvalid ? mem64(paddr) : {$urandom, $urandom};
      imem_gnt       = ($urandom_range(0, 2) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = pick_pc();
      inst_ready     = ($urandom_range(0, 3) != 0);
      #1;
      if (redirect_valid) chk("rand_valid_in_redirect", 32'(inst_valid), 32'd0);
      if (imem_req) chk("rand_single_outstanding", 32'(pend), 32'd0);
      if (prev_val && !prev_rdy && !prev_rd) begin
        chk("rand_hold_valid", 32'(inst_valid || redirect_valid), 32'd1);
        chk("rand_hold_inst", inst, prev_inst);
        chk("rand_hold_pc", inst_pc, prev_ipc);
        chk("rand_hold_fault", 32'(inst_fault), 32'(prev_flt));
      end
      if (inst_valid && inst_ready) begin
        exp_flt  = (exp_pc[1:0] != 2'b00);
        exp_inst = exp_flt ? 32'h0 : word_at(exp_pc);
        chk("rand_inst_pc", inst_pc, exp_pc);
        chk("rand_inst", inst, exp_inst);
        chk("rand_fault", 32'(inst_fault), 32'(exp_flt));
        $display("consume pc=%h inst=%h fault=%b", inst_pc, inst, inst_fault);
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
      if (redirect_valid) exp_pc = redirect_pc;
      prev_val = inst_valid; prev_rdy = inst_ready; prev_rd = redirect_valid;
      prev_inst = inst; prev_ipc = inst_pc; prev_flt = inst_fault;
      if (imem_rvalid) pend = 1'b0;
      else if (pend) cnt--;
      if (imem_req && imem_gnt) begin
        pend  = 1'b1;
        cnt   = $urandom_range(0, 2);
        paddr = imem_addr;
      end
    end
    checks++;
    if (consumed < 100) begin
      failures++;
      $display("FAIL rand_progress actual=%0d consumed required>=100", consumed);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction fetch unit for the NPC core: owns the program counter, fetches 32-bit instructions from a 64-bit instruction memory over a request/grant/response handshake, and presents each instruction with its PC to decode over a valid/ready handshake. It sits directly upstream of the decode/register-file/ALU datapath, replacing the free-running PC register plus externally supplied instruction. Execute stage redirects (branches/jumps) flush any in-flight fetch.

## Interface
- RESET_PC, 32'h8000_0000, PC of first fetch after reset
- clk  in  1  core clock, all state on rising edge
- rstn  in  1  asynchronous active-low reset
- imem_req  out  1  fetch request, held until imem_gnt
- imem_addr  out  32  {pc[31:3],3'b000}, doubleword-aligned fetch address
- imem_gnt  in  1  memory accepts request this cycle
- imem_rvalid  in  1  response data valid, earliest one cycle after gnt
- imem_rdata  in  64  response doubleword
- redirect_valid  in  1  execute redirect, single-cycle pulse
- redirect_pc  in  32  redirect target
- inst_valid  out  1  instruction available to decode
- inst_ready  in  1  decode consumes instruction
- inst  out  32  fetched instruction
- inst_pc  out  32  PC of inst
- inst_fault  out  1  misaligned fetch (pc[1:0]!=0); inst is 32'h0

## Operation
- Single outstanding request; FSM states IDLE, REQ, WAIT, HOLD; internal pc register.
- IDLE: entered on reset; next cycle → REQ (or HOLD with fault if pc[1:0]!=0).
- REQ: imem_req=1; imem_gnt → WAIT; request stays high, addr stable, until gnt.
- WAIT: imem_rvalid → capture imem_rdata[63:32] if pc[2]=1 else [31:0] into inst, inst_pc<=pc, → HOLD.
- HOLD: inst_valid=1; inst_ready → pc<=pc+4, → REQ (or HOLD-with-fault if new pc misaligned).
- Misaligned pc: no memory request; inst=0, inst_fault=1, inst_valid=1 in HOLD; consumed normally.
- PC arithmetic mod 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- Redirect (highest priority, any state): pc<=redirect_pc; inst_valid forced 0 in the redirect cycle (combinational), so no handshake completes that cycle.
  - IDLE/HOLD: → REQ next cycle (held instruction discarded).
  - REQ without gnt: stay REQ, addr retargets next cycle.
  - REQ with gnt same cycle, or WAIT: set discard flag, → WAIT; the pending response is dropped on rvalid, flag cleared, → REQ.
  - WAIT with rvalid same cycle: response dropped, → REQ.
  - Redirect while discard already set: pc updated, flag stays set, still exactly one response dropped.
- imem_rvalid outside WAIT is ignored.

## Timing
- Reset (async assert, sync release): imem_req=0, imem_addr={RESET_PC[31:3],3'b000}, inst_valid=0, inst=0, inst_pc=RESET_PC, inst_fault=0, discard=0, state=IDLE.
- Reset mid-fetch aborts; outstanding memory response after release is ignored.
- Best-case loop, gnt immediate and rvalid next cycle: c0 REQ/gnt, c1 rvalid, c2 inst_valid (ready) , c3 next REQ → 3 cycles/instruction.
- inst, inst_pc, inst_fault stable while inst_valid=1 and inst_ready=0.
- Redirect to first REQ of target: 1 cycle (if nothing in flight).

## Test plan
- Reset release, gnt immediate, rvalid +1 cycle, rdata=64'h00500093_00100093, ready=1 → first inst=32'h00100093 @ inst_pc 0x8000_0000, second fetch addr 0x8000_0000 gives 32'h00500093 @ 0x8000_0004, third addr 0x8000_0008.
- Hold gnt low 4 cycles, then ready low 3 cycles in HOLD → imem_req held and addr stable; inst/inst_pc stable; pc advances only on ready.
- Redirect to 0x8000_0100 during WAIT, rvalid 2 cycles later with 64'hDEAD_BEEF_DEAD_BEEF → response dropped, no inst_valid, next REQ addr 0x8000_0100.
- Redirect in HOLD same cycle as inst_ready=1 → inst_valid low that cycle, pc=redirect_pc, next fetch to target not pc+4.
- Redirect to 0x8000_0102 → no imem_req, inst_valid=1, inst_fault=1, inst=0, inst_pc=0x8000_0102.
- redirect_pc=32'hFFFF_FFFC, consume → next fetch addr 32'h0000_0000, inst_pc 0x0.
